// File: rtl/output_row_packer.sv
// output_row_packer
// Collects a serial stream of result elements into 64-element rows and
// issues one row-wide write per completed row to the output memory.
// A start pulse drains a full ROWS x ROW_LEN matrix; done pulses at the end.
module output_row_packer #(
    parameter int DATA_WIDTH    = 16,
    parameter int ROW_LEN       = 64,
    parameter int ROWS          = 64,
    parameter int ADDR_WIDTH_PS = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic                          in_ready,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_WIDTH_PS-1:0]      mem_addr,
    output logic [DATA_WIDTH*ROW_LEN-1:0] mem_din,
    output logic                          busy,
    output logic                          done
);

    localparam int COL_W = $clog2(ROW_LEN);
    localparam int BUF_W = DATA_WIDTH * ROW_LEN;

    localparam logic [COL_W-1:0]         COL_LAST = COL_W'(ROW_LEN - 1);
    localparam logic [COL_W-1:0]         COL_ZERO = {COL_W{1'b0}};
    localparam logic [COL_W-1:0]         COL_ONE  = {{(COL_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH_PS-1:0] ROW_LAST = ADDR_WIDTH_PS'(ROWS - 1);
    localparam logic [ADDR_WIDTH_PS-1:0] ROW_ZERO = {ADDR_WIDTH_PS{1'b0}};
    localparam logic [ADDR_WIDTH_PS-1:0] ROW_ONE  = {{(ADDR_WIDTH_PS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [COL_W-1:0]         col_q,   col_d;
    logic [ADDR_WIDTH_PS-1:0] row_q,   row_d;
    logic [BUF_W-1:0]         buf_q,   buf_d;

    // Next-state logic: lane capture, column/row counting and drain sequencing.
    // The column counter parks at the last lane on the final accept and is
    // cleared on the way out of WRITE, so it never wraps inside a drain.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        buf_d   = buf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    col_d   = COL_ZERO;
                    row_d   = ROW_ZERO;
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (in_valid) begin
                    buf_d[DATA_WIDTH*col_q +: DATA_WIDTH] = in_data;
                    if (col_q == COL_LAST) begin
                        state_d = ST_WRITE;
                    end else begin
                        col_d = col_q + COL_ONE;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_WRITE: begin
                if (row_q == ROW_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    row_d   = row_q + ROW_ONE;
                    col_d   = COL_ZERO;
                    state_d = ST_FILL;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and row buffer; synchronous reset aborts any drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            col_q   <= COL_ZERO;
            row_q   <= ROW_ZERO;
            buf_q   <= {BUF_W{1'b0}};
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            buf_q   <= buf_d;
        end
    end

    // Moore output decode from the registered state; address and data come
    // straight from the row counter and row buffer registers.
    always_comb begin
        in_ready = 1'b0;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_q)
            ST_IDLE:  busy     = 1'b0;
            ST_FILL:  in_ready = 1'b1;
            ST_WRITE: begin
                mem_en = 1'b1;
                mem_we = 1'b1;
            end
            ST_DONE:  done     = 1'b1;
            default:  busy     = 1'b0;
        endcase
        mem_addr = row_q;
        mem_din  = buf_q;
    end

endmodule

// File: tb/tb_output_row_packer.sv
// Scoreboard bench for output_row_packer: an open-loop driver plans each
// drain cycle by cycle and queues the row writes and done pulse it expects;
// a negedge monitor pops and compares whenever the DUT writes or pulses done.
module tb_output_row_packer;

    localparam int DW  = 16;
    localparam int RL  = 64;
    localparam int NR  = 64;
    localparam int AW  = 6;
    localparam int BW  = DW * RL;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_din;
    logic          busy;
    logic          done;

    output_row_packer #(
        .DATA_WIDTH(DW), .ROW_LEN(RL), .ROWS(NR), .ADDR_WIDTH_PS(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            addr;
        logic [BW-1:0] data;
        int            cyc;
    } wr_t;

    wr_t           wq[$];
    int            dq[$];
    logic [BW-1:0] mem_rows [NR];
    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    int            t0;
    int            t;
    int            st_a   = -1;
    int            st_b   = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares every DUT write and done pulse with the queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                wr_t e;
                chk("we_in_ready_low", in_ready, 0);
                chk("we_mem_en", mem_en, 1);
                chk("we_busy", busy, 1);
                mem_rows[mem_addr] = mem_din;
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr %0d at cycle %0d", mem_addr, cyc);
                end else begin
                    e = wq.pop_front();
                    chk("write_addr", mem_addr, e.addr);
                    chk("write_cycle", cyc, e.cyc);
                    checks++;
                    if (mem_din !== e.data) begin
                        errors++;
                        for (int j = 0; j < RL; j++) begin
                            if (mem_din[j*DW +: DW] !== e.data[j*DW +: DW]) begin
                                $display("FAIL write_data row %0d lane %0d got %h expected %h",
                                         e.addr, j, mem_din[j*DW +: DW], e.data[j*DW +: DW]);
                                break;
                            end
                        end
                    end
                end
            end
            if (done) begin
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done at cycle %0d", cyc);
                end else begin
                    chk("done_cycle", cyc, dq.pop_front());
                end
            end
        end
    end

    // One driver cycle: apply inputs, advance one clock, sample point #1 after.
    task automatic drive(input logic v, input logic [DW-1:0] d);
        start    = (t == st_a) || (t == st_b);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        t++;
    endtask

    // Plan a complete drain: element (k,j) carries base + k*64 + j.
    task automatic run_drain(input logic [DW-1:0] base, input bit stalls, input bit offer);
        logic [BW-1:0] rowv;
        logic [DW-1:0] v;
        wr_t           e;
        start    = 1'b1;
        in_valid = 1'b0;
        t0       = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        t     = 1;
        for (int k = 0; k < NR; k++) begin
            for (int j = 0; j < RL; j++) begin
                if (stalls && $urandom_range(0, 3) == 0) begin
                    int ns = $urandom_range(1, 3);
                    for (int s = 0; s < ns; s++) drive(1'b0, DW'($urandom));
                end
                v = base + DW'(k * RL + j);
                drive(1'b1, v);
                rowv[j*DW +: DW] = v;
            end
            e.addr = k;
            e.data = rowv;
            e.cyc  = t0 + t;
            wq.push_back(e);
            drive(offer, base + DW'((k + 1) * RL));
        end
        dq.push_back(t0 + t);
        drive(1'b0, '0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_din_zero"}, longint'(mem_din == '0), 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        wr_t e;
        rst = 1'b1; start = 1'b1; in_valid = 1'b0; in_data = '0; t = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        chk("start_with_rst_idle", busy, 0);

        // Full drain, no stalls, then memory round trip
        run_drain(16'h0000, 1'b0, 1'b0);
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < RL; c++)
                chk("mem_round_trip", mem_rows[r][c*DW +: DW], r * RL + c);

        // Back-to-back drain with random stalls and data offered during WRITE
        run_drain(DW'($urandom), 1'b1, 1'b1);

        // Start pulses while busy must be ignored
        st_a = 10; st_b = 3000;
        run_drain(DW'($urandom), 1'b0, 1'b1);
        st_a = -1; st_b = -1;

        // Another stalled drain straight after
        run_drain(DW'($urandom), 1'b1, 1'b0);

        // Reset two cycles mid-FILL of row 1
        start = 1'b1; in_valid = 1'b0; t0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0; t = 1;
        for (int j = 0; j < RL; j++) begin
            drive(1'b1, DW'(j));
            e.data[j*DW +: DW] = DW'(j);
        end
        e.addr = 0;
        e.cyc  = t0 + t;
        wq.push_back(e);
        drive(1'b1, 16'hAAAA);
        for (int j = 0; j < 35; j++) drive(1'b1, DW'($urandom));
        rst = 1'b1;
        drive(1'b1, 16'h5555);
        drive(1'b1, 16'h5555);
        rst = 1'b0;
        check_all_zero("midfill_reset");
        for (int i = 0; i < 150; i++) begin
            drive(1'b1, DW'($urandom));
            if (i % 50 == 0) begin
                chk("post_reset_busy", busy, 0);
                chk("post_reset_in_ready", in_ready, 0);
            end
        end

        repeat (4) @(posedge clk);
        #1;
        chk("pending_writes", wq.size(), 0);
        chk("pending_dones", dq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/output_row_packer.md
# output_row_packer

Packs a serial stream of result elements from the compute array into full 64-element rows and writes each row into the output memory through its row-wide port (port A). It sits directly upstream of the output memory: the array drains results one element per beat over a valid/ready handshake, and this block turns them into one row write per 64 elements. A software-triggered `start` begins a full 64×64 matrix drain, and `done` marks its completion.

## Interface
- `DATA_WIDTH`, 16, width of one result element.
- `ROW_LEN`, 64, elements per row; the packed row is `DATA_WIDTH*ROW_LEN` bits.
- `ROWS`, 64, rows per matrix.
- `ADDR_WIDTH_PS`, 6, row address width; equals log2(`ROWS`).

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a matrix drain; sampled only in IDLE.
- `in_valid`  in  1  upstream element valid.
- `in_data`  in  `DATA_WIDTH`  upstream element.
- `in_ready`  out  1  block accepts an element this cycle.
- `mem_en`  out  1  to output memory `en_a`.
- `mem_we`  out  1  to output memory `we_a`.
- `mem_addr`  out  `ADDR_WIDTH_PS`  to output memory `addr_a` (row index).
- `mem_din`  out  `DATA_WIDTH*ROW_LEN`  to output memory `din_a` (packed row).
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse after the last row write.

## Operation
- FSM states: IDLE, FILL, WRITE, DONE.
- **IDLE**
  - `in_ready`=0.
  - On `start`: clear the column counter `col` and row counter `row` to 0, then go to FILL.
- **FILL**
  - `in_ready`=1.
  - On accept (`in_valid && in_ready`): store `in_data` at lane `col`, i.e. row-buffer bits [`DATA_WIDTH*col +: DATA_WIDTH`].
    - Element 0 sits in the LSBs. This matches the memory's element-wise read-back order.
  - On accept with `col`<`ROW_LEN`-1: increment `col`.
  - On accept with `col`=`ROW_LEN`-1: go to WRITE.
  - Cycles without `in_valid`: hold all state (stalls allowed at any beat).
- **WRITE** (exactly one cycle)
  - `mem_en`=1, `mem_we`=1, `mem_addr`=`row`, `mem_din`=row buffer.
  - Buffer contents include the element accepted in the previous cycle.
  - `in_ready`=0.
  - Next state:
    - `row`=`ROWS`-1: go to DONE.
    - Otherwise: `row` increments, `col` clears to 0, go to FILL.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
- Outputs are Moore, decoded from registered state.
  - `mem_en`/`mem_we` are low in all states except WRITE.
  - `mem_addr` and `mem_din` are don't-care outside WRITE but must be driven from registers (no X).
- The row buffer is not cleared between rows; every lane is overwritten before each WRITE.
- `start` while `busy` is ignored. No restart and no counter change.
- Data is passed bit-exact: no arithmetic or truncation.
- Counter widths: `col` is log2(`ROW_LEN`) bits, `row` is `ADDR_WIDTH_PS` bits. Neither counter may wrap inside a drain.

## Timing
- Reset: state=IDLE, `col`=0, `row`=0, row buffer=0.
  - All outputs read 0 from the first cycle after `rst`: `in_ready`, `mem_en`, `mem_we`, `mem_addr`, `mem_din`, `busy`, `done`.
- `rst` asserted mid-drain (any state) aborts the drain.
  - No further memory write occurs after `rst` is sampled.
  - `done` is not pulsed.
- `start` sampled at cycle 0:
  - FILL (and `in_ready`) begins at cycle 1.
  - `busy` is high from cycle 1.
- With `in_valid` held high:
  - Accepts occur at cycles 1..64, WRITE at cycle 65, next FILL at cycle 66.
  - Each row takes 65 cycles.
  - Last WRITE is at cycle 4160, `done` is high at cycle 4161, IDLE from cycle 4162.
- Each stall cycle in FILL delays all later events by exactly one cycle.
- `in_ready` drops in the WRITE cycle. An upstream element offered then is not consumed and must be held by upstream.
- `start` coincident with `rst`: reset wins and the block stays in IDLE.

## Test plan
- **Reset**: assert `rst` 2 cycles mid-FILL.
  - Every output reads 0 after reset.
  - `busy`=0, and no `mem_we` pulse occurs afterwards.
- **Full drain, no stalls**: pulse `start`; stream values `row*64+col` continuously.
  - Exactly 64 WRITE cycles, at cycles 65+65k with `mem_addr`=k.
  - Lane j of `mem_din` = k*64+j.
  - `done` is high only at cycle 4161.
- **Random stalls**: toggle `in_valid` pseudo-randomly.
  - Captured rows match the no-stall run.
  - WRITE count = 64.
  - `in_ready` is low on every WRITE cycle.
- **Start while busy**: pulse `start` at cycles 10 and 3000 of a drain.
  - Timing is identical to the single-start run.
  - Only one `done` pulse.
- **Back-to-back drains**: pulse `start` in the cycle after `done` returns low.
  - The second drain writes addresses 0..63 again with new data.
  - First-row lanes show no residue from the previous matrix.
- **Memory round trip**: connect to the output memory.
  - After a drain, element-wise reads at element address r*64+c return r*64+c.
